// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory map: FSM state encoding,
// region base/limit helpers and the ATmega32A default sizes.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SRAM_RD,
        RESP
    } state_t;

    localparam int ATMEGA_NUM_GPR    = 32;
    localparam int ATMEGA_NUM_IO     = 64;
    localparam int ATMEGA_SRAM_DEPTH = 2048;

    // Regions are laid out back to back: GPR, then IO, then SRAM.
    function automatic int gpr_base();
        return 0;
    endfunction

    function automatic int io_base(input int num_gpr);
        return num_gpr;
    endfunction

    function automatic int sram_base(input int num_gpr, input int num_io);
        return num_gpr + num_io;
    endfunction

    // First address past the end of SRAM; anything at or above is unmapped.
    function automatic int sram_limit(input int num_gpr, input int num_io,
                                      input int depth);
        return num_gpr + num_io + depth;
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port SRAM with registered read.
// Ports: clk; en enables the access; we selects write; addr/wdata in;
// rdata is the registered read result. A write returns the old contents.
// Contents are not reset.
module sram_sp #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_map.sv
// AVR-style data memory map. Decodes a request address into the register
// file, I/O register space or internal SRAM and completes it through a
// small IDLE/SRAM_RD/RESP FSM.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   req_*                   - request handshake, address, write data, IN/OUT flag
//   gpr_bus, io_bus         - packed register/IO byte views (reads)
//   gpr_we/gpr_waddr, io_we/io_waddr, wdata - write strobes to register owners
//   rsp_valid/rsp_rdata/rsp_err - one-cycle completion
module data_mem_map
    import data_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int NUM_GPR    = ATMEGA_NUM_GPR,
    parameter int NUM_IO     = ATMEGA_NUM_IO,
    parameter int SRAM_DEPTH = ATMEGA_SRAM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic                       req_we,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic                       req_io_only,
    input  logic [NUM_GPR*DATA_W-1:0]  gpr_bus,
    input  logic [NUM_IO*DATA_W-1:0]   io_bus,
    output logic                       gpr_we,
    output logic [$clog2(NUM_GPR)-1:0] gpr_waddr,
    output logic                       io_we,
    output logic [$clog2(NUM_IO)-1:0]  io_waddr,
    output logic [DATA_W-1:0]          wdata,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err
);

    localparam int GPR_AW  = $clog2(NUM_GPR);
    localparam int IO_AW   = $clog2(NUM_IO);
    localparam int SRAM_AW = $clog2(SRAM_DEPTH);

    localparam logic [31:0] IO_LO   = 32'(io_base(NUM_GPR));
    localparam logic [31:0] SRAM_LO = 32'(sram_base(NUM_GPR, NUM_IO));
    localparam logic [31:0] SRAM_HI = 32'(sram_limit(NUM_GPR, NUM_IO, SRAM_DEPTH));

    state_t state, state_nxt;

    // Decode is done on a 32-bit effective address so the IN/OUT offset
    // can never wrap back into a valid region.
    logic [31:0] addr_ext, ea, io_off, sram_off;
    logic        dec_err, hit_gpr, hit_io, hit_sram, accept;
    logic [GPR_AW-1:0]  gpr_idx;
    logic [IO_AW-1:0]   io_idx;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_q;
    logic               sram_en, sram_we;

    assign addr_ext = 32'(req_addr);
    assign ea       = addr_ext + (req_io_only ? 32'(NUM_GPR) : 32'd0);
    assign dec_err  = (req_io_only && addr_ext >= 32'(NUM_IO)) || ea >= SRAM_HI;
    assign hit_gpr  = !dec_err && ea < IO_LO;
    assign hit_io   = !dec_err && ea >= IO_LO && ea < SRAM_LO;
    assign hit_sram = !dec_err && ea >= SRAM_LO;

    assign io_off    = ea - IO_LO;
    assign sram_off  = ea - SRAM_LO;
    assign gpr_idx   = ea[GPR_AW-1:0];
    assign io_idx    = io_off[IO_AW-1:0];
    assign sram_addr = sram_off[SRAM_AW-1:0];

    // Upper offset bits are meaningless once the region is known.
    logic unused_bits;
    assign unused_bits = ^{ea[31:GPR_AW], io_off[31:IO_AW], sram_off[31:SRAM_AW]};

    logic [DATA_W-1:0] gpr_arr [NUM_GPR];
    logic [DATA_W-1:0] io_arr  [NUM_IO];

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
        assign gpr_arr[g] = gpr_bus[g*DATA_W +: DATA_W];
    end
    for (genvar g = 0; g < NUM_IO; g++) begin : g_io
        assign io_arr[g] = io_bus[g*DATA_W +: DATA_W];
    end

    assign accept  = (state == IDLE) && req_valid;
    assign sram_en = accept && hit_sram;
    assign sram_we = sram_en && req_we;

    sram_sp #(
        .DEPTH (SRAM_DEPTH),
        .WIDTH (DATA_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (req_wdata),
        .rdata (sram_q)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (hit_sram && !req_we) ? SRAM_RD : RESP;
            end
            SRAM_RD: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is loaded on the edge that enters RESP, so it only
    // changes when a new response is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            gpr_we    <= 1'b0;
            io_we     <= 1'b0;
            gpr_waddr <= '0;
            io_waddr  <= '0;
            wdata     <= '0;
        end else begin
            gpr_we <= 1'b0;
            io_we  <= 1'b0;
            if (accept) begin
                gpr_we    <= req_we && hit_gpr;
                io_we     <= req_we && hit_io;
                gpr_waddr <= gpr_idx;
                io_waddr  <= io_idx;
                wdata     <= req_wdata;
                rsp_err   <= dec_err;
                if (dec_err)
                    rsp_rdata <= '1;
                else if (req_we)
                    rsp_rdata <= '0;
                else if (hit_gpr)
                    rsp_rdata <= gpr_arr[gpr_idx];
                else if (hit_io)
                    rsp_rdata <= io_arr[io_idx];
            end
            if (state == SRAM_RD)
                rsp_rdata <= sram_q;
        end
    end

endmodule

// File: tb/tb_data_mem_map.sv
module tb_data_mem_map;

    localparam int NG = 32;
    localparam int NI = 64;
    localparam int ND = 2048;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [15:0]  req_addr = '0;
    logic         req_we = 1'b0;
    logic [7:0]   req_wdata = '0;
    logic         req_io_only = 1'b0;
    logic [NG*8-1:0] gpr_bus = '0;
    logic [NI*8-1:0] io_bus = '0;
    logic         gpr_we, io_we, rsp_valid, rsp_err;
    logic [4:0]   gpr_waddr;
    logic [5:0]   io_waddr;
    logic [7:0]   wdata, rsp_rdata;

    data_mem_map #(
        .DATA_W(8), .ADDR_W(16), .NUM_GPR(NG), .NUM_IO(NI), .SRAM_DEPTH(ND)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_io_only(req_io_only),
        .gpr_bus(gpr_bus), .io_bus(io_bus),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .io_we(io_we), .io_waddr(io_waddr),
        .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: bus bytes and the SRAM bytes written so far.
    logic [7:0] gpr_m [NG];
    logic [7:0] io_m  [NI];
    logic [7:0] sram_m [int];
    logic [7:0] last_rd = 8'h00;
    bit         last_known = 1'b1;
    bit         hold_bus = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic pack_buses();
        for (int i = 0; i < NG; i++) gpr_bus[i*8 +: 8] = gpr_m[i];
        for (int i = 0; i < NI; i++) io_bus[i*8 +: 8] = io_m[i];
    endtask

    task automatic shuffle_buses();
        for (int i = 0; i < NG; i++) gpr_m[i] = 8'($urandom);
        for (int i = 0; i < NI; i++) io_m[i] = 8'($urandom);
        pack_buses();
    endtask

    // One request, checked cycle by cycle against the memory-map rules.
    task automatic tx(input bit io, input int addr, input bit we, input logic [7:0] wd);
        int ea, kind, idx, lat;
        bit err, known;
        logic [7:0] exp_rd;
        ea   = addr + (io ? NG : 0);
        err  = (io && addr >= NI) || ea >= NG + NI + ND;
        kind = (ea < NG) ? 0 : (ea < NG + NI) ? 1 : 2;
        idx  = (kind == 0) ? ea : (kind == 1) ? ea - NG : ea - NG - NI;
        lat  = (!err && kind == 2 && !we) ? 2 : 1;
        known = 1'b1;

        @(negedge clk);
        if (!hold_bus) shuffle_buses();
        req_valid = 1'b1; req_io_only = io; req_addr = 16'(addr);
        req_we = we; req_wdata = wd;
        chk("req_ready_idle", req_ready, 1);

        if (err)            exp_rd = 8'hFF;
        else if (we)        exp_rd = 8'h00;
        else if (kind == 0) exp_rd = gpr_m[idx];
        else if (kind == 1) exp_rd = io_m[idx];
        else if (sram_m.exists(idx)) exp_rd = sram_m[idx];
        else begin exp_rd = 8'h00; known = 1'b0; end

        @(posedge clk);
        if (!err && kind == 2 && we) sram_m[idx] = wd;

        @(negedge clk);
        req_valid = 1'b0;
        if (!hold_bus) shuffle_buses();
        chk("gpr_we", gpr_we, (!err && we && kind == 0) ? 1 : 0);
        chk("io_we", io_we, (!err && we && kind == 1) ? 1 : 0);
        if (!err && we && kind == 0) begin
            chk("gpr_waddr", gpr_waddr, idx);
            chk("wdata_gpr", wdata, wd);
        end
        if (!err && we && kind == 1) begin
            chk("io_waddr", io_waddr, idx);
            chk("wdata_io", wdata, wd);
        end
        if (lat == 1) begin
            chk("rsp_valid_1", rsp_valid, 1);
            chk("rsp_err", rsp_err, err);
            chk("rsp_rdata", rsp_rdata, exp_rd);
        end else begin
            chk("rsp_valid_early", rsp_valid, 0);
            chk("req_ready_busy", req_ready, 0);
            if (last_known) chk("rdata_hold", rsp_rdata, last_rd);
            @(negedge clk);
            chk("rsp_valid_2", rsp_valid, 1);
            chk("rsp_err_sram", rsp_err, 0);
            chk("no_strobe_sram", {gpr_we, io_we}, 0);
            if (known) chk("rsp_rdata_sram", rsp_rdata, exp_rd);
        end
        last_rd = exp_rd;
        last_known = known;
    endtask

    initial begin
        shuffle_buses();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_strobes", {gpr_we, io_we}, 0);

        // Directed cases with pinned bus bytes.
        hold_bus = 1'b1;
        gpr_m[5] = 8'hA5; io_m[63] = 8'h3C; pack_buses();
        tx(0, 16'h0005, 0, 8'h00);
        tx(1, 16'h003F, 0, 8'h00);
        tx(0, 16'h005F, 0, 8'h00);
        hold_bus = 1'b0;
        tx(0, 16'h0060, 1, 8'h5A);
        tx(0, 16'h0060, 0, 8'h00);
        tx(0, 16'h0025, 1, 8'h77);
        tx(0, 16'h085F, 1, 8'hC3);
        tx(0, 16'h085F, 0, 8'h00);
        tx(0, 16'h0860, 0, 8'h00);
        tx(1, 16'h0040, 1, 8'h99);
        tx(0, 16'h0860, 1, 8'h11);
        tx(0, 16'hFFFF, 0, 8'h00);
        tx(0, 16'h0060, 0, 8'h00);
        tx(0, 16'h001F, 1, 8'h42);
        tx(0, 16'h0020, 1, 8'h24);
        for (int i = 0; i < 16; i++) tx(0, 96 + i, 1, 8'($urandom));

        // Reset while an SRAM read is in flight.
        @(negedge clk);
        req_valid = 1'b1; req_io_only = 1'b0; req_addr = 16'h0060; req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        chk("midrst_no_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", req_ready, 1);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("midrst_valid_late", rsp_valid, 0);
        last_rd = 8'h00; last_known = 1'b1;

        // Randomized traffic over all regions and the error space.
        for (int n = 0; n < 300; n++) begin
            int r, a;
            bit io;
            io = 1'b0;
            r = $urandom_range(0, 5);
            case (r)
                0: a = $urandom_range(0, NG - 1);
                1: a = $urandom_range(NG, NG + NI - 1);
                2: begin io = 1'b1; a = $urandom_range(0, NI - 1); end
                3, 4: a = NG + NI + $urandom_range(0, 15);
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = NG + NI + ND + $urandom_range(0, 200);
                        1: begin io = 1'b1; a = $urandom_range(NI, 255); end
                        default: a = 16'hFFFF;
                    endcase
                end
            endcase
            tx(io, a, 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
